// File: rtl/uart_tx_drain.sv
// uart_tx_drain: drains a FWFT TX FIFO and serialises each word as a UART frame on o_tx.
module uart_tx_drain #(
  parameter int DW        = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIVW      = 16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_enable,
  input  logic [DIVW-1:0] i_div,
  input  logic            i_fifo_empty,
  input  logic [DW-1:0]   i_fifo_data,
  output logic            o_fifo_rd,
  output logic            o_tx,
  output logic            o_busy,
  output logic            o_done
);
  localparam int BCW = $clog2(DW);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;
  logic [2:0]      state, state_n;
  logic [DW-1:0]   shreg, shreg_n;
  logic [DIVW-1:0] div_q, div_n, baud_cnt, baud_n;
  logic [BCW-1:0]  bit_cnt, bit_n;
  logic            par_acc, par_n, tick, last, pop, tx_n;
  assign tick      = baud_cnt == '0;
  assign last      = state == STOP && tick && bit_cnt == '0;
  assign pop       = ~i_reset & i_enable & ~i_fifo_empty & (state == IDLE | last);
  assign o_fifo_rd = pop;
  assign o_busy    = state != IDLE;
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    div_n   = div_q;
    bit_n   = bit_cnt;
    par_n   = par_acc;
    baud_n  = state == IDLE ? baud_cnt : tick ? div_q : baud_cnt - 1'b1;
    if (tick)
      case (state)
        START: state_n = DATA;
        DATA: begin
          shreg_n = shreg >> 1;
          state_n = bit_cnt != '0 ? DATA : PARITY != 0 ? PAR : STOP;
          bit_n   = bit_cnt != '0 ? bit_cnt - 1'b1 : BCW'(STOP_BITS - 1);
        end
        PAR:  state_n = STOP;
        STOP: begin
          state_n = bit_cnt != '0 ? STOP : IDLE;
          bit_n   = bit_cnt != '0 ? bit_cnt - 1'b1 : bit_cnt;
        end
        default: ;
      endcase
    // a pop in the final stop cycle overrides the return to IDLE, giving zero gap
    if (pop) begin
      state_n = START;
      shreg_n = i_fifo_data;
      div_n   = i_div;
      baud_n  = i_div;
      bit_n   = BCW'(DW - 1);
      par_n   = PARITY == 2 ? ~^i_fifo_data : ^i_fifo_data;
    end
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shreg_n[0] : state_n == PAR ? par_n : 1'b1;
  end
  always_ff @(posedge i_clk)
    if (i_reset) begin
      state    <= IDLE;
      shreg    <= '0;
      div_q    <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      par_acc  <= 1'b0;
      o_tx     <= 1'b1;
      o_done   <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      div_q    <= div_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      par_acc  <= par_n;
      o_tx     <= tx_n;
      o_done   <= last;
    end
endmodule

// File: tb/tb_uart_tx_drain.sv
// tb_uart_tx_drain: scoreboarded bench; expected per-cycle line levels are queued at each pop.
module tb_uart_tx_drain;
  logic        clk, rst, en, empty, rd, tx, busy, done;
  logic [15:0] div;
  logic [7:0]  data;
  logic        empty_p, rd1, rd2, tx1, tx2, busy1, busy2, done1, done2;
  logic [15:0] div_p;
  logic [7:0]  data_p;
  int total = 0, bad = 0, pops = 0, dones = 0, p0, d0;
  logic [7:0] fq[$];
  logic [1:0] etx[$];
  logic cur_idle = 1'b1, cur_last = 1'b0, done_pend = 1'b0;

  uart_tx_drain #(.DW(8), .PARITY(0), .STOP_BITS(1), .DIVW(16)) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_div(div), .i_fifo_empty(empty),
    .i_fifo_data(data), .o_fifo_rd(rd), .o_tx(tx), .o_busy(busy), .o_done(done));
  uart_tx_drain #(.DW(8), .PARITY(1), .STOP_BITS(2), .DIVW(16)) dut_even (
    .i_clk(clk), .i_reset(rst), .i_enable(1'b1), .i_div(div_p), .i_fifo_empty(empty_p),
    .i_fifo_data(data_p), .o_fifo_rd(rd1), .o_tx(tx1), .o_busy(busy1), .o_done(done1));
  uart_tx_drain #(.DW(8), .PARITY(2), .STOP_BITS(2), .DIVW(16)) dut_odd (
    .i_clk(clk), .i_reset(rst), .i_enable(1'b1), .i_div(div_p), .i_fifo_empty(empty_p),
    .i_fifo_data(data_p), .o_fifo_rd(rd2), .o_tx(tx2), .o_busy(busy2), .o_done(done2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    empty = fq.size() == 0;
    data  = empty ? 8'h00 : fq[0];
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    refresh();
  endtask

  function automatic logic expb(input int par, input logic [7:0] d, input int dv, input int k);
    int b;
    b = k / (dv + 1);
    return b == 0 ? 1'b0 : b <= 8 ? d[b-1] : b == 9 ? (par == 1 ? ^d : ~^d) : 1'b1;
  endfunction

  // One clock: predict/compare the pop, queue the frame, then check the next cycle's outputs.
  task automatic step();
    logic rd_now, exp_rd, r;
    logic [1:0] e;
    #1;
    r      = rst;
    exp_rd = !rst && en && !empty && (cur_idle || cur_last);
    rd_now = rd;
    chk("rd", {15'd0, rd_now}, {15'd0, exp_rd});
    if (exp_rd)
      for (int b = 0; b < 10; b++)
        for (int c = 0; c <= int'(div); c++)
          etx.push_back({b == 9 && c == int'(div), b == 0 ? 1'b0 : b == 9 ? 1'b1 : data[b-1]});
    @(posedge clk);
    @(negedge clk);
    if (rd_now) begin
      void'(fq.pop_front());
      pops++;
    end
    refresh();
    if (r) begin
      etx.delete();
      done_pend = 1'b0;
    end
    chk("busy", {15'd0, busy}, {15'd0, etx.size() != 0});
    chk("done", {15'd0, done}, {15'd0, done_pend});
    if (done) dones++;
    if (etx.size() != 0) begin
      e = etx.pop_front();
      cur_idle = 1'b0;
    end else begin
      e = 2'b01;
      cur_idle = 1'b1;
    end
    chk("tx", {15'd0, tx}, {15'd0, e[0]});
    cur_last  = e[1];
    done_pend = e[1];
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; div = 16'd3;
    empty_p = 1'b1; div_p = 16'd2; data_p = 8'h07;
    refresh();
    step();
    step();
    chk("rst_tx1", {15'd0, tx1}, 16'd1);
    chk("rst_busy2", {15'd0, busy2}, 16'd0);
    rst = 1'b0;
    // single byte 0xA5, 4-cycle bits
    en = 1'b1; p0 = pops; d0 = dones;
    push(8'hA5);
    repeat (45) step();
    chk("single_pops", 16'(pops - p0), 16'd1);
    chk("single_dones", 16'(dones - d0), 16'd1);
    // streaming three bytes at 1-cycle bits
    div = 16'd0; p0 = pops; d0 = dones;
    push(8'h00); push(8'hFF); push(8'h55);
    repeat (35) step();
    chk("stream_pops", 16'(pops - p0), 16'd3);
    chk("stream_dones", 16'(dones - d0), 16'd3);
    chk("stream_empty", {15'd0, empty}, 16'd1);
    chk("stream_busy", {15'd0, busy}, 16'd0);
    // even and odd parity, two stop bits, byte 0x07
    empty_p = 1'b0;
    #1;
    chk("par_rd1", {15'd0, rd1}, 16'd1);
    chk("par_rd2", {15'd0, rd2}, 16'd1);
    step();
    empty_p = 1'b1;
    for (int k = 0; k < 36; k++) begin
      chk("even_tx", {15'd0, tx1}, {15'd0, expb(1, 8'h07, 2, k)});
      chk("odd_tx", {15'd0, tx2}, {15'd0, expb(2, 8'h07, 2, k)});
      chk("par_done", {15'd0, done1 | done2}, 16'd0);
      step();
    end
    chk("even_done", {15'd0, done1}, 16'd1);
    chk("odd_done", {15'd0, done2}, 16'd1);
    chk("even_idle", {15'd0, tx1 & ~busy1}, 16'd1);
    chk("odd_idle", {15'd0, tx2 & ~busy2}, 16'd1);
    // enable dropped mid-frame with two bytes queued
    div = 16'd1; p0 = pops;
    push(8'h3C); push(8'h81);
    repeat (5) step();
    en = 1'b0;
    repeat (30) step();
    chk("en_pops", 16'(pops - p0), 16'd1);
    chk("en_fifo", 16'(fq.size()), 16'd1);
    en = 1'b1;
    step();
    chk("reen_pops", 16'(pops - p0), 16'd2);
    repeat (22) step();
    // reset in DATA aborts the frame; next byte goes out normally
    div = 16'd2; d0 = dones;
    push(8'h96); push(8'h4B);
    repeat (6) step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    repeat (40) step();
    chk("rst_fifo", 16'(fq.size()), 16'd0);
    chk("rst_dones", 16'(dones - d0), 16'd1);
    // divisor change mid-frame takes effect at the next pop
    div = 16'd3; p0 = pops; d0 = dones;
    push(8'h5A); push(8'hC3);
    repeat (11) step();
    div = 16'd7;
    repeat (125) step();
    chk("div_pops", 16'(pops - p0), 16'd2);
    chk("div_dones", 16'(dones - d0), 16'd2);
    chk("final_busy", {15'd0, busy}, 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_drain.md
# uart_tx_drain

Transmit-side controller for the UART block. It drains bytes from the shared synchronous TX FIFO, which has a first-word-fall-through read port, and serialises each byte onto `o_tx` as an asynchronous frame. The frame has one start bit, DW data bits LSB first, optional parity and 1 or 2 stop bits. The block sits between the FIFO read side and the pad, and owns the FIFO read strobe exclusively.

## Interface
- `DW`, 8, data bits per frame (5..9); matches FIFO data width.
- `PARITY`, 0, 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1, stop bits per frame (1 or 2).
- `DIVW`, 16, width of baud divisor.

- `i_clk`  in  1  clock.
- `i_reset`  in  1  reset; synchronous, active-high.
- `i_enable`  in  1  permits starting new frames.
- `i_div`  in  DIVW  bit period minus one, in `i_clk` cycles.
- `i_fifo_empty`  in  1  FIFO empty flag.
- `i_fifo_data`  in  DW  FIFO head word (valid combinationally while not empty).
- `o_fifo_rd`  out  1  FIFO pop strobe, combinational.
- `o_tx`  out  1  serial line, idle high.
- `o_busy`  out  1  frame in progress (state != IDLE).
- `o_done`  out  1  one-cycle pulse after a frame's final stop-bit cycle.

## Operation
- States:
  - IDLE
  - START
  - DATA
  - PARITY (skipped when `PARITY`=0)
  - STOP
- Registers:
  - `shreg[DW-1:0]`
  - `div_q[DIVW-1:0]`, latched per frame
  - `baud_cnt[DIVW-1:0]`
  - `bit_cnt` (counts DW-1..0, and stop bits)
  - `par_acc`
- Pop condition `pop` = `~i_reset & i_enable & ~i_fifo_empty & (state==IDLE | last_tick_of_final_stop)`; `o_fifo_rd` = `pop`. A pop is never issued while `i_fifo_empty`=1.
- On `pop`:
  - `shreg` <= `i_fifo_data`, `div_q` <= `i_div`, `baud_cnt` <= `i_div`, `bit_cnt` <= DW-1.
  - `par_acc` <= ^`i_fifo_data` for even parity, ~^`i_fifo_data` for odd.
  - State <= START.
- tick = (`baud_cnt`==0). Each non-IDLE cycle: if tick, `baud_cnt` <= `div_q`; else decrement.
- Transitions on tick:
  - START -> DATA.
  - DATA: `shreg` >>= 1; if `bit_cnt`==0 then go to PARITY, or to STOP when there is no parity; else decrement `bit_cnt`. On leaving DATA, `bit_cnt` <= `STOP_BITS`-1.
  - PARITY -> STOP.
  - STOP: if `bit_cnt`≠0, decrement. Otherwise this tick is `last_tick_of_final_stop`: if `pop`, go to START with the new byte loaded; else go to IDLE.
- `o_tx` by state:
  - IDLE: 1
  - START: 0
  - DATA: `shreg[0]`
  - PARITY: `par_acc`
  - STOP: 1
- `o_tx` is registered from next-state/next-`shreg`, so no glitches.
- `o_done` is registered: 1 in the cycle following `last_tick_of_final_stop`.
- `i_enable` low mid-frame: the current frame completes; no further pops.
- `i_div` changes mid-frame are ignored until the next pop.
- `i_div`=0 is legal: 1 cycle per bit.

## Timing
- Reset values:
  - state = IDLE, `o_tx` = 1, `o_busy` = 0, `o_done` = 0.
  - `shreg`, `baud_cnt`, `bit_cnt`, `par_acc` = 0.
  - `o_fifo_rd` = 0 while `i_reset`=1.
- Pop in cycle N (IDLE): `o_tx` falls to 0 and `o_busy` rises at cycle N+1.
- Each bit is held exactly `i_div`+1 cycles.
- Frame length F = (1 + DW + (PARITY≠0) + STOP_BITS)·(`i_div`+1) cycles.
- Back-to-back: the next pop coincides with the final stop cycle, so the next start bit begins with zero idle gap. Pop period = F.
- `o_done` asserts in the cycle after the last stop cycle, concurrent with the next start bit when streaming.
- Reset mid-frame aborts the frame: `o_tx`=1 from the next cycle. The popped byte is lost.
- `i_fifo_empty` rising in the final stop cycle gives no pop; the block enters IDLE and `o_tx` stays 1.
- FIFO underflow/overflow flags never assert due to this block.

## Test plan
- Single byte, DW=8, PARITY=0, STOP_BITS=1, `i_div`=3, push 0xA5:
  - exactly one `o_fifo_rd` pulse.
  - `o_tx` sequence 0,1,0,1,0,0,1,0,1,1, each for 4 cycles (40 cycles).
  - `o_done` pulses once at cycle 41 after the pop.
- Streaming 3 bytes 0x00, 0xFF, 0x55 at `i_div`=0:
  - pops 10 cycles apart.
  - no idle-high cycle between frames.
  - 3 `o_done` pulses.
  - FIFO empty afterwards, `o_busy`=0.
- PARITY=1 then PARITY=2, STOP_BITS=2, byte 0x07:
  - parity bit = 1 (even), 0 (odd).
  - two stop bits of `i_div`+1 cycles each.
- `i_enable` dropped mid-frame with 2 bytes queued:
  - the current frame finishes; no second pop.
  - re-enable: pop on the next cycle.
- Reset asserted in the DATA state:
  - next cycle `o_tx`=1, `o_busy`=0, `o_fifo_rd`=0.
  - after release, the next queued byte transmits normally.
- `i_div` changed from 3 to 7 mid-frame:
  - the current frame keeps 4-cycle bits.
  - the next frame uses 8-cycle bits.
